// File: rtl/parking_pkg.sv
// parking_pkg: shared types, alarm bit indices and helpers for the parking controller
package parking_pkg;
    localparam int CNT_W = 8;
    localparam int ALM_UNAUTH = 0;
    localparam int ALM_OVF    = 1;
    localparam int ALM_UNF    = 2;
    localparam int ALM_SENS   = 3;
    typedef enum logic {IDLE, OPEN} gate_state_t;
    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int k = 0; k < 8; k++) n = n + 4'(v[k]);
        return n;
    endfunction
endpackage

// File: rtl/parking_gate_fsm.sv
// parking_gate_fsm: one entry gate, holds a reservation while OPEN until entry, timeout or sensor error
module parking_gate_fsm
    import parking_pkg::*;
#(
    parameter int TIMEOUT = 64
)(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_grant,
    input  logic i_in,
    input  logic i_sens_err,
    output logic o_open,
    output logic o_busy
);
    localparam int TW = $clog2(TIMEOUT + 1);
    gate_state_t r_state;
    logic [TW-1:0] r_timer;
    logic r_open;
    // state, open-cycle timer and registered gate drive
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_open  <= 1'b0;
        end else if (r_state == IDLE) begin
            r_timer <= '0;
            if (i_grant) begin
                r_state <= OPEN;
                r_open  <= 1'b1;
            end
        end else if (i_in || i_sens_err || r_timer == TW'(TIMEOUT - 1)) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_open  <= 1'b0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end
    assign o_open = r_open;
    assign o_busy = (r_state == OPEN);
endmodule

// File: rtl/parking_occupancy_ctrl.sv
// parking_occupancy_ctrl: occupancy counter, round-robin gate arbiter and sticky alarms
module parking_occupancy_ctrl
    import parking_pkg::*;
#(
    parameter int N_ENTRY  = 2,
    parameter int CAPACITY = 16,
    parameter int TIMEOUT  = 64
)(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N_ENTRY-1:0] i_req,
    input  logic [N_ENTRY-1:0] i_in,
    input  logic [N_ENTRY-1:0] i_out,
    input  logic [N_ENTRY-1:0] i_sens_err,
    output logic [N_ENTRY-1:0] o_gate_open,
    output logic [CNT_W-1:0]   o_count,
    output logic               o_full,
    output logic               o_empty,
    output logic [3:0]         o_alarm
);
    localparam int PW = N_ENTRY > 1 ? $clog2(N_ENTRY) : 1;
    logic [N_ENTRY-1:0] w_busy;
    logic [N_ENTRY-1:0] w_grant;
    logic [N_ENTRY-1:0] w_cand;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      w_gidx;
    logic               w_found;
    logic               w_has_free;
    logic [9:0]         w_reserved;
    logic [9:0]         w_occ;
    logic [9:0]         w_sum;
    logic               w_over;
    logic               w_under;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_next;
    logic               r_empty;
    logic [3:0]         r_alarm;
    logic [3:0]         w_alarm_next;

    genvar g;
    generate
        for (g = 0; g < N_ENTRY; g++) begin : g_gate
            parking_gate_fsm #(.TIMEOUT(TIMEOUT)) u_gate (
                .i_clk      (i_clk),
                .i_rst_n    (i_rst_n),
                .i_grant    (w_grant[g]),
                .i_in       (i_in[g]),
                .i_sens_err (i_sens_err[g]),
                .o_open     (o_gate_open[g]),
                .o_busy     (w_busy[g])
            );
        end
    endgenerate

    // arbitration on pre-update free slots, then netted and clamped occupancy
    always_comb begin
        w_reserved = 10'(popcount(8'(w_busy)));
        w_occ      = 10'(r_count) + w_reserved;
        w_has_free = w_occ < 10'(CAPACITY);
        w_cand     = ~w_busy & i_req & ~i_sens_err;
        w_grant    = '0;
        w_gidx     = r_ptr;
        w_found    = 1'b0;
        for (int k = 1; k <= N_ENTRY; k++) begin
            if (!w_found && w_has_free && w_cand[(int'(r_ptr) + k) % N_ENTRY]) begin
                w_grant[(int'(r_ptr) + k) % N_ENTRY] = 1'b1;
                w_gidx  = PW'((int'(r_ptr) + k) % N_ENTRY);
                w_found = 1'b1;
            end
        end
        w_sum        = 10'(r_count) + 10'(popcount(8'(i_in))) - 10'(popcount(8'(i_out)));
        w_under      = w_sum[9];
        w_over       = !w_sum[9] && (w_sum > 10'(CAPACITY));
        w_count_next = w_under ? '0 : w_over ? CNT_W'(CAPACITY) : w_sum[CNT_W-1:0];
        w_alarm_next = r_alarm;
        w_alarm_next[ALM_UNAUTH] = r_alarm[ALM_UNAUTH] | (|(i_in & ~w_busy));
        w_alarm_next[ALM_OVF]    = r_alarm[ALM_OVF] | w_over;
        w_alarm_next[ALM_UNF]    = r_alarm[ALM_UNF] | w_under;
        w_alarm_next[ALM_SENS]   = r_alarm[ALM_SENS] | (|i_sens_err);
    end

    // occupancy, empty flag, sticky alarms and round-robin pointer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_empty <= 1'b1;
            r_alarm <= '0;
            r_ptr   <= PW'(N_ENTRY - 1);
        end else begin
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_alarm <= w_alarm_next;
            if (w_found) r_ptr <= w_gidx;
        end
    end

    // full is decoded only from registered count and gate states, never from inputs
    assign o_full  = w_occ >= 10'(CAPACITY);
    assign o_count = r_count;
    assign o_empty = r_empty;
    assign o_alarm = r_alarm;
endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// tb_parking_occupancy_ctrl: directed scenarios on a default instance and a CAPACITY=2/TIMEOUT=8 instance
module tb_parking_occupancy_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = '0, in_p = '0, out_p = '0, serr = '0;
    logic [1:0] gate, c_gate;
    logic [7:0] count, c_count;
    logic       full, empty, c_full, c_empty;
    logic [3:0] alarm, c_alarm;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    parking_occupancy_ctrl #(.N_ENTRY(2), .CAPACITY(16), .TIMEOUT(64)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_in(in_p), .i_out(out_p), .i_sens_err(serr),
        .o_gate_open(gate), .o_count(count), .o_full(full), .o_empty(empty), .o_alarm(alarm)
    );

    parking_occupancy_ctrl #(.N_ENTRY(2), .CAPACITY(2), .TIMEOUT(8)) u_cap (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_in(in_p), .i_out(out_p), .i_sens_err(serr),
        .o_gate_open(c_gate), .o_count(c_count), .o_full(c_full), .o_empty(c_empty), .o_alarm(c_alarm)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0; in_p = '0; out_p = '0; serr = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (gate !== 2'b00 || count !== 8'd0 || full !== 1'b0 || empty !== 1'b1 || alarm !== 4'd0) begin
            failures++;
            $display("FAIL reset: gate=%b count=%0d full=%b empty=%b alarm=%b, want 00 0 0 1 0000", gate, count, full, empty, alarm);
        end
        checks++;
        if (c_gate !== 2'b00 || c_count !== 8'd0 || c_full !== 1'b0 || c_empty !== 1'b1 || c_alarm !== 4'd0) begin
            failures++;
            $display("FAIL reset_cap: gate=%b count=%0d full=%b empty=%b alarm=%b", c_gate, c_count, c_full, c_empty, c_alarm);
        end
    endtask

    task automatic test_single_entry();
        do_reset();
        req = 2'b01;
        step();
        checks++;
        if (gate !== 2'b01 || count !== 8'd0) begin
            failures++;
            $display("FAIL grant_latency: gate=%b count=%0d, want 01 0", gate, count);
        end
        req = 2'b00; in_p = 2'b01;
        step();
        in_p = 2'b00;
        checks++;
        if (gate !== 2'b00 || count !== 8'd1 || empty !== 1'b0 || alarm !== 4'd0) begin
            failures++;
            $display("FAIL entry_close: gate=%b count=%0d empty=%b alarm=%b, want 00 1 0 0000", gate, count, empty, alarm);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_gate;
        do_reset();
        req = 2'b11;
        step();
        checks++;
        if (gate !== 2'b01) begin
            failures++;
            $display("FAIL rr_first: gate=%b, want 01", gate);
        end
        exp_gate = 2'b01;
        for (int n = 1; n <= 4; n++) begin
            in_p = exp_gate;
            exp_gate = ~exp_gate;
            step();
            checks++;
            if (gate !== exp_gate || count !== 8'(n)) begin
                failures++;
                $display("FAIL rr_alt%0d: gate=%b count=%0d, want %b %0d", n, gate, count, exp_gate, n);
            end
        end
        in_p = '0; req = '0;
        checks++;
        if (alarm !== 4'd0) begin
            failures++;
            $display("FAIL rr_alarm: alarm=%b, want 0000", alarm);
        end
    endtask

    task automatic test_capacity();
        do_reset();
        in_p = 2'b01;
        step();
        in_p = 2'b00; req = 2'b11;
        step();
        checks++;
        if (c_gate !== 2'b01 || c_count !== 8'd1 || c_full !== 1'b1) begin
            failures++;
            $display("FAIL cap_grant: gate=%b count=%0d full=%b, want 01 1 1", c_gate, c_count, c_full);
        end
        for (int n = 0; n < 7; n++) step();
        checks++;
        if (c_gate !== 2'b01 || c_full !== 1'b1) begin
            failures++;
            $display("FAIL cap_hold: gate=%b full=%b, want 01 1", c_gate, c_full);
        end
        step();
        checks++;
        if (c_gate !== 2'b00 || c_full !== 1'b0) begin
            failures++;
            $display("FAIL cap_timeout: gate=%b full=%b, want 00 0", c_gate, c_full);
        end
        step();
        checks++;
        if (c_gate !== 2'b10 || c_full !== 1'b1) begin
            failures++;
            $display("FAIL cap_regrant: gate=%b full=%b, want 10 1", c_gate, c_full);
        end
        req = '0;
    endtask

    task automatic test_underflow_unauth();
        do_reset();
        out_p = 2'b10;
        step();
        out_p = 2'b00;
        checks++;
        if (count !== 8'd0 || alarm !== 4'b0100 || empty !== 1'b1) begin
            failures++;
            $display("FAIL underflow: count=%0d alarm=%b empty=%b, want 0 0100 1", count, alarm, empty);
        end
        in_p = 2'b01;
        step();
        in_p = 2'b00;
        checks++;
        if (count !== 8'd1 || alarm !== 4'b0101) begin
            failures++;
            $display("FAIL unauth: count=%0d alarm=%b, want 1 0101", count, alarm);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        in_p = 2'b11;
        step();
        checks++;
        if (c_count !== 8'd2 || c_alarm !== 4'b0001) begin
            failures++;
            $display("FAIL ovf_edge: count=%0d alarm=%b, want 2 0001", c_count, c_alarm);
        end
        step();
        in_p = 2'b00;
        checks++;
        if (c_count !== 8'd2 || c_alarm !== 4'b0011 || c_full !== 1'b1) begin
            failures++;
            $display("FAIL overflow: count=%0d alarm=%b full=%b, want 2 0011 1", c_count, c_alarm, c_full);
        end
        checks++;
        if (count !== 8'd4) begin
            failures++;
            $display("FAIL ovf_wide: count=%0d, want 4", count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_p = 2'b11;
        step();
        step();
        in_p = 2'b01;
        step();
        in_p = 2'b00; req = 2'b01;
        step();
        checks++;
        if (count !== 8'd5 || gate !== 2'b01) begin
            failures++;
            $display("FAIL net_setup: count=%0d gate=%b, want 5 01", count, gate);
        end
        req = 2'b00; in_p = 2'b01; out_p = 2'b10;
        step();
        in_p = 2'b00; out_p = 2'b00;
        checks++;
        if (count !== 8'd5 || gate !== 2'b00 || alarm !== 4'b0001) begin
            failures++;
            $display("FAIL net_same_cycle: count=%0d gate=%b alarm=%b, want 5 00 0001", count, gate, alarm);
        end
    endtask

    task automatic test_sens_err();
        do_reset();
        in_p = 2'b01;
        step();
        in_p = 2'b00; req = 2'b10;
        step();
        checks++;
        if (gate !== 2'b10 || c_full !== 1'b1) begin
            failures++;
            $display("FAIL serr_grant: gate=%b cap_full=%b, want 10 1", gate, c_full);
        end
        req = 2'b00; serr = 2'b10;
        step();
        serr = 2'b00;
        checks++;
        if (gate !== 2'b00 || alarm !== 4'b1001 || c_full !== 1'b0 || c_gate !== 2'b00) begin
            failures++;
            $display("FAIL serr_close: gate=%b alarm=%b cap_full=%b cap_gate=%b, want 00 1001 0 00", gate, alarm, c_full, c_gate);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        in_p = 2'b01;
        step();
        in_p = 2'b00; req = 2'b01;
        step();
        checks++;
        if (gate !== 2'b01 || count !== 8'd1 || alarm !== 4'b0001) begin
            failures++;
            $display("FAIL areset_setup: gate=%b count=%0d alarm=%b, want 01 1 0001", gate, count, alarm);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (gate !== 2'b00 || count !== 8'd0 || empty !== 1'b1 || alarm !== 4'd0 || full !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: gate=%b count=%0d empty=%b alarm=%b full=%b, want 00 0 1 0000 0", gate, count, empty, alarm, full);
        end
        req = 2'b00;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_entry();
        test_round_robin();
        test_capacity();
        test_underflow_unauth();
        test_overflow();
        test_back_to_back();
        test_sens_err();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
